bram_stream_reader: RTL and testbench



---
 rtl/bram_stream_reader_pkg.sv | 13 +
 rtl/bram_stream_reader_if.sv | 18 +
 rtl/bram_stream_reader_fifo.sv | 49 ++++
 rtl/bram_stream_reader.sv | 156 +++++++++++++++
 tb/tb_bram_stream_reader.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/bram_stream_reader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bram_stream_reader_pkg                                                     |
// | Constants shared by the BRAM stream reader and its buffer.                 |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package bram_stream_reader_pkg;

    // Depth of the output buffer; read credit starts at this value.
    localparam int unsigned c_BUF_DEPTH = 2;

endpackage
`default_nettype wire

// File: rtl/bram_stream_reader_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bram_stream_reader_if                                                      |
// | Valid/ready stream carrying data words and an end-of-transfer marker.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface bram_stream_reader_if #(
    parameter int DATA_WIDTH = 32
) ();
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  ready;
    logic                  last;

    modport master (output data, output valid, output last, input ready);
    modport slave  (input data, input valid, input last, output ready);
endinterface
`default_nettype wire

// File: rtl/bram_stream_reader_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | stream_fifo2                                                               |
// | Two-entry synchronous FIFO with head-of-queue output.                      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module stream_fifo2 #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_din,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_dout,
    output logic                  o_full,
    output logic                  o_empty
);
    logic [DATA_WIDTH-1:0] r_mem [2];
    logic                  r_wptr;
    logic                  r_rptr;
    logic [1:0]            r_cnt;
    logic                  w_rd;

    assign w_rd    = i_pop && !o_empty;
    assign o_full  = (r_cnt == 2'd2);
    assign o_empty = (r_cnt == 2'd0);
    assign o_dout  = r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wptr   <= 1'b0;
            r_rptr   <= 1'b0;
            r_cnt    <= 2'd0;
        end else begin
            if (i_push) begin
                r_mem[r_wptr] <= i_din;
                r_wptr        <= ~r_wptr;
            end
            if (w_rd) begin
                r_rptr <= ~r_rptr;
            end
            r_cnt <= r_cnt + 2'(i_push) - 2'(w_rd);
        end
    end
endmodule
`default_nettype wire

// File: rtl/bram_stream_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bram_stream_reader                                                         |
// | Reads a contiguous BRAM range and emits it as a valid/ready stream.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module bram_stream_reader
    import bram_stream_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    input  logic [ADDR_WIDTH:0]   i_count,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [ADDR_WIDTH-1:0] o_bram_addr,
    output logic                  o_bram_wr,
    output logic [DATA_WIDTH-1:0] o_bram_din,
    input  logic [DATA_WIDTH-1:0] i_bram_dout,
    bram_stream_reader_if.master  m_stream
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    localparam int                  c_CREDIT_W = 2;
    localparam logic [ADDR_WIDTH:0] c_CNT_ONE  = 1;
    localparam logic [ADDR_WIDTH-1:0] c_ADDR_ONE = 1;

    state_e                  r_state;
    state_e                  w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [ADDR_WIDTH:0]     r_count;
    logic [ADDR_WIDTH:0]     r_issued;
    logic [ADDR_WIDTH:0]     r_delivered;
    logic [c_CREDIT_W-1:0]   r_credit;
    logic                    r_inflight;
    logic                    r_done;

    logic                    w_issue;
    logic                    w_load;
    logic                    w_done_nxt;
    logic                    w_pop;
    logic                    w_push;
    logic                    w_is_last;
    logic                    w_full;
    logic                    w_empty;
    logic [DATA_WIDTH-1:0]   w_head;

    assign w_pop     = !w_empty && m_stream.ready;
    assign w_is_last = ((r_delivered + c_CNT_ONE) == r_count);
    assign w_push    = r_inflight && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A handshake frees a buffer slot in the same cycle, so it counts as credit.
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_load      = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    if (i_count != '0) begin
                        w_load      = 1'b1;
                        w_state_nxt = ST_READ;
                    end else begin
                        w_done_nxt = 1'b1;
                    end
                end
            end
            ST_READ: begin
                w_issue = (r_credit != '0) || w_pop;
                if (w_issue && ((r_issued + c_CNT_ONE) == r_count)) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_pop && w_is_last) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr      <= '0;
            r_count     <= '0;
            r_issued    <= '0;
            r_delivered <= '0;
            r_credit    <= c_CREDIT_W'(c_BUF_DEPTH);
            r_inflight  <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            r_done     <= w_done_nxt;
            if (w_load) begin
                r_addr      <= i_base_addr;
                r_count     <= i_count;
                r_issued    <= '0;
                r_delivered <= '0;
                r_credit    <= c_CREDIT_W'(c_BUF_DEPTH);
            end else begin
                if (w_issue) begin
                    r_addr   <= r_addr + c_ADDR_ONE;
                    r_issued <= r_issued + c_CNT_ONE;
                end
                if (w_pop) begin
                    r_delivered <= r_delivered + c_CNT_ONE;
                end
                r_credit <= r_credit - c_CREDIT_W'(w_issue) + c_CREDIT_W'(w_pop);
            end
        end
    end

    stream_fifo2 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_din   (i_bram_dout),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign o_busy         = (r_state != ST_IDLE);
    assign o_done         = r_done;
    assign o_bram_addr    = r_addr;
    assign o_bram_wr      = 1'b0;
    assign o_bram_din     = '0;
    assign m_stream.data  = w_head;
    assign m_stream.valid = !w_empty;
    assign m_stream.last  = !w_empty && w_is_last;
endmodule
`default_nettype wire

// File: tb/tb_bram_stream_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_bram_stream_reader                                                      |
// | Scoreboard bench: RAM model, random backpressure, queued expected words.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_bram_stream_reader;
    typedef struct {
        logic [31:0] data;
        logic        last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_start = 1'b0;
    logic [9:0]  i_base_addr = '0;
    logic [10:0] i_count = '0;
    logic        o_busy;
    logic        o_done;
    logic [9:0]  o_bram_addr;
    logic        o_bram_wr;
    logic [31:0] o_bram_din;
    logic [31:0] bram_dout = '0;
    logic [31:0] mem [1024];

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   done_cnt = 0;
    int   done_cyc = -1;
    int   hs_cnt  = 0;
    int   last_cyc = -1;
    int   first_valid_cyc = -1;
    bit   busy_seen = 0;
    int   rdy_mode = 0;
    bit   prev_stall = 0;
    logic [31:0] prev_data = '0;
    exp_t exp_q[$];

    bram_stream_reader_if #(.DATA_WIDTH(32)) s_if ();

    bram_stream_reader #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (10)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_start     (i_start),
        .i_base_addr (i_base_addr),
        .i_count     (i_count),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_bram_addr (o_bram_addr),
        .o_bram_wr   (o_bram_wr),
        .o_bram_din  (o_bram_din),
        .i_bram_dout (bram_dout),
        .m_stream    (s_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) bram_dout <= mem[o_bram_addr];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_stall = 0;
        end else begin
            if (o_busy) busy_seen = 1;
            if (s_if.valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (o_done) begin
                done_cnt++;
                done_cyc = cyc;
                check("done_pending_words", 64'(exp_q.size()), 0);
                check("busy_at_done", o_busy, 0);
            end
            if (prev_stall) begin
                check("hold_valid", s_if.valid, 1);
                check("hold_data", s_if.data, prev_data);
            end
            if (s_if.valid && s_if.ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_word: got 0x%0h, expected no word (cycle %0d)", s_if.data, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("word_data", s_if.data, e.data);
                    check("word_last", s_if.last, e.last);
                    hs_cnt++;
                    if (s_if.last) last_cyc = cyc;
                end
            end
            prev_stall = s_if.valid && !s_if.ready;
            prev_data  = s_if.data;
        end
    end

    initial begin
        s_if.ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       s_if.ready = 1'b1;
                1:       s_if.ready = ($urandom_range(0, 99) < 30);
                default: s_if.ready = ($urandom_range(0, 99) < 80);
            endcase
        end
    end

    // Called at posedge+1; returns at posedge+1 of the following cycle.
    task automatic start_xfer(input int base, input int count, input bit expect_words);
        exp_t e;
        i_start     = 1'b1;
        i_base_addr = 10'(base);
        i_count     = 11'(count);
        if (expect_words) begin
            for (int k = 0; k < count; k++) begin
                e.data = mem[(base + k) % 1024];
                e.last = (k == count - 1);
                exp_q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        i_start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int start_cnt;
        int k;
        start_cnt = done_cnt;
        k = 0;
        while (done_cnt == start_cnt && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        check({name, "_done_seen"}, 64'(done_cnt != start_cnt), 1);
        check({name, "_queue_empty"}, 64'(exp_q.size()), 0);
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, "_busy"}, o_busy, 0);
        check({name, "_done"}, o_done, 0);
        check({name, "_valid"}, s_if.valid, 0);
        check({name, "_last"}, s_if.last, 0);
        check({name, "_addr"}, o_bram_addr, 0);
        check({name, "_data"}, s_if.data, 0);
        check({name, "_wr"}, o_bram_wr, 0);
        check({name, "_din"}, o_bram_din, 0);
    endtask

    initial begin
        int n;
        int d0;
        int k;
        for (int i = 0; i < 1024; i++) mem[i] = 32'(i + 'h100);

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic transfer with timing checks
        rdy_mode = 0;
        n = cyc;
        first_valid_cyc = -1;
        start_xfer('h010, 8, 1);
        check("t1_busy", o_busy, 1);
        check("t1_first_addr", o_bram_addr, 'h010);
        wait_done("t1", 100);
        check("t1_first_valid_cycle", 64'(first_valid_cyc), 64'(n + 3));
        check("t1_last_cycle", 64'(last_cyc), 64'(n + 10));
        check("t1_done_cycle", 64'(done_cyc), 64'(n + 11));

        // Address wrap
        start_xfer('h3FE, 4, 1);
        wait_done("wrap", 100);

        // Backpressure
        rdy_mode = 1;
        start_xfer('h100, 16, 1);
        wait_done("bp", 2000);
        rdy_mode = 0;

        // Zero count
        n = cyc;
        busy_seen = 0;
        first_valid_cyc = -1;
        start_xfer('h050, 0, 1);
        wait_done("zero", 10);
        check("zero_done_cycle", 64'(done_cyc), 64'(n + 1));
        check("zero_busy_seen", 64'(busy_seen), 0);
        check("zero_no_valid", 64'(first_valid_cyc), 64'(-1));

        // Full-depth transfer
        rdy_mode = 2;
        start_xfer('h155, 1024, 1);
        wait_done("full", 10000);

        // Start while busy is ignored
        rdy_mode = 1;
        start_xfer('h040, 8, 1);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        start_xfer('h200, 5, 0);
        wait_done("ignore", 2000);
        repeat (20) begin
            @(posedge clk);
            #1;
        end

        // Reset mid-transfer
        rdy_mode = 0;
        d0 = hs_cnt;
        start_xfer('h080, 8, 1);
        k = 0;
        while (hs_cnt - d0 < 3 && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("rst_mid_reached_3", 64'(hs_cnt - d0 >= 3), 1);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_outputs_zero("rst_mid");
        d0 = done_cnt;
        repeat (20) begin
            @(posedge clk);
            #1;
        end
        check("rst_mid_no_done", 64'(done_cnt), 64'(d0));
        start_xfer('h020, 2, 1);
        wait_done("after_rst", 100);

        // Random transfers
        for (int t = 0; t < 8; t++) begin
            int b;
            int c;
            rdy_mode = $urandom_range(0, 2);
            b = $urandom_range(0, 1023);
            c = $urandom_range(1, 40);
            start_xfer(b, c, 1);
            wait_done("rand", c * 40 + 50);
        end

        rdy_mode = 0;
        repeat (5) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
